adder_32bit_pipe: RTL
=====================

Name: adder_32bit_pipe

Overview:
- Two-stage pipelined 32-bit adder with valid/ready handshakes on input and output.
- Stage 1 adds the low 16-bit halves and registers the carry; stage 2 adds the high halves using that carry.
- Sits between the operand-issue logic and the result consumer, where a single-cycle combinational 32-bit add is too slow for the target clock.
- Sustains one add per cycle and honours downstream backpressure without dropping or duplicating results.

Parameters:
- HALF_W, 16, width of each pipeline half; total width is 2*HALF_W (32 by default).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears state immediately, release is synchronous to clk.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts operand beat this cycle.
- A  input  32  operand A.
- B  input  32  operand B.
- Cin  input  1  carry in to bit 0.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result this cycle.
- S  output  32  sum, A+B+Cin modulo 2^32.
- C32  output  1  carry out of bit 31.
- OVF  output  1  signed two's-complement overflow: A[31]==B[31] and S[31]!=A[31].

Behaviour:
- Arithmetic: unsigned; {C32,S} = A + B + Cin, computed as 33 bits.
- Stage 1 registers:
  - s1_valid.
  - s1_lo = low HALF_W bits of A[15:0]+B[15:0]+Cin.
  - s1_c16 = carry out of that low-half add.
  - s1_ah = A[31:16], s1_bh = B[31:16].
- Stage 2 registers:
  - s2_valid.
  - S = {s2_hi, s1_lo carried}.
  - C32.
  - OVF, computed from s1_ah[15], s1_bh[15] and the high-half sum MSB.
- Outputs S, C32, OVF and out_valid are driven directly from stage 2 registers; no combinational path from A/B to outputs.
- Advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
- Per cycle:
  - If s2_adv: stage 2 loads stage 1 contents and s2_valid <= s1_valid.
  - If s1_adv: stage 1 loads new operands and s1_valid <= in_valid & in_ready.
  - Data registers may load when not valid; only the valid bits are architectural.
- Latency: a beat accepted in cycle N appears with out_valid=1 in cycle N+2 if out_ready stays high.
- Throughput: 1 beat/cycle with out_ready held high.
- Backpressure:
  - With out_ready low and both stages valid, in_ready=0.
  - S/C32/OVF stay stable while out_valid & !out_ready.
  - At most 2 beats are held in flight.
- in_ready depends combinationally on out_ready; this is permitted. The block has no combinational in_valid-to-out path.
- Ordering: results leave in acceptance order; none dropped or duplicated.
- Reset:
  - s1_valid=0, s2_valid=0, out_valid=0, S=0, C32=0, OVF=0.
  - in_ready=1 once reset is released (both stages empty).
- Reset mid-operation discards all in-flight beats. The first accepted beat after reset release follows normal latency.
- Wrap-around: 0xFFFFFFFF + 0x00000001 gives S=0, C32=1, OVF=0.
- Cin=1 propagates through both halves in the same pipeline beat.
- Simultaneous events: an input accept and an output transfer in the same cycle are both honoured, with occupancy unchanged.

Test Plan:
- Reset then single beat: A=0x00000001, B=0x00000002, Cin=0, out_ready=1 -> out_valid high 2 cycles after accept, S=0x00000003, C32=0, OVF=0.
- Carry across halves: A=0x0000FFFF, B=0x00000001, Cin=0 -> S=0x00010000, C32=0; A=0xFFFFFFFF, B=0x00000000, Cin=1 -> S=0, C32=1.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001 -> S=0x80000000, OVF=1, C32=0; A=0x80000000, B=0x80000000 -> S=0, C32=1, OVF=1.
- Streaming: 100 random beats with in_valid=1 and out_ready=1 -> one result per cycle after a 2-cycle fill, all matching a 33-bit reference model, in order.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 beats accepted, in_ready=0 thereafter, S stable; release out_ready -> remaining beats drain in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with both stages valid -> out_valid falls immediately (asynchronous); after release in_ready=1, no stale result emitted, and the next beat has 2-cycle latency.

Source files
------------

// File: rtl/adder_32bit_pipe_if.sv
// Operand/result handshake bundle for the two-stage pipelined adder.
// The slave side is the adder; the master side is the issuer plus consumer.
interface adder_32bit_pipe_if #(
  parameter int HALF_W = 16
) ();
  localparam int W = 2 * HALF_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         C32;
  logic         OVF;

  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, S, C32, OVF
  );

  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, S, C32, OVF
  );
endinterface

// File: rtl/adder_32bit_pipe.sv
// Two-stage pipelined adder: low halves summed in stage 1, high halves plus the
// registered mid carry in stage 2, with valid/ready flow control on both sides.
module adder_32bit_pipe #(
  parameter int HALF_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  adder_32bit_pipe_if.slave   bus
);
  localparam int W = 2 * HALF_W;

  logic              s1_valid_q, s1_valid_d;
  logic [HALF_W-1:0] s1_lo_q,    s1_lo_d;
  logic              s1_c16_q,   s1_c16_d;
  logic [HALF_W-1:0] s1_ah_q,    s1_ah_d;
  logic [HALF_W-1:0] s1_bh_q,    s1_bh_d;

  logic              s2_valid_q, s2_valid_d;
  logic [W-1:0]      s2_sum_q,   s2_sum_d;
  logic              s2_c32_q,   s2_c32_d;
  logic              s2_ovf_q,   s2_ovf_d;

  logic              s1_adv_s;
  logic              s2_adv_s;
  logic [HALF_W:0]   lo_sum_s;
  logic [HALF_W:0]   hi_sum_s;

  // Advance chain: a stage may load when it is empty or its successor moves.
  always_comb begin
    s2_adv_s = !s2_valid_q || bus.out_ready;
    s1_adv_s = !s1_valid_q || s2_adv_s;
  end

  // Half-width adders, one extra bit each to capture the carry out.
  always_comb begin
    lo_sum_s = {1'b0, bus.A[HALF_W-1:0]} + {1'b0, bus.B[HALF_W-1:0]}
             + {{HALF_W{1'b0}}, bus.Cin};
    hi_sum_s = {1'b0, s1_ah_q} + {1'b0, s1_bh_q} + {{HALF_W{1'b0}}, s1_c16_q};
  end

  // Stage 1 next state: capture new operands whenever the stage can advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_c16_d   = s1_c16_q;
    s1_ah_d    = s1_ah_q;
    s1_bh_d    = s1_bh_q;
    if (s1_adv_s) begin
      s1_valid_d = bus.in_valid;
      s1_lo_d    = lo_sum_s[HALF_W-1:0];
      s1_c16_d   = lo_sum_s[HALF_W];
      s1_ah_d    = bus.A[W-1:HALF_W];
      s1_bh_d    = bus.B[W-1:HALF_W];
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: finish the high half and derive signed overflow.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_c32_d   = s2_c32_q;
    s2_ovf_d   = s2_ovf_q;
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      s2_sum_d   = {hi_sum_s[HALF_W-1:0], s1_lo_q};
      s2_c32_d   = hi_sum_s[HALF_W];
      s2_ovf_d   = (s1_ah_q[HALF_W-1] == s1_bh_q[HALF_W-1])
                && (hi_sum_s[HALF_W-1] != s1_ah_q[HALF_W-1]);
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers; reset empties both stages and zeroes the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= {HALF_W{1'b0}};
      s1_c16_q   <= 1'b0;
      s1_ah_q    <= {HALF_W{1'b0}};
      s1_bh_q    <= {HALF_W{1'b0}};
      s2_valid_q <= 1'b0;
      s2_sum_q   <= {W{1'b0}};
      s2_c32_q   <= 1'b0;
      s2_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_c16_q   <= s1_c16_d;
      s1_ah_q    <= s1_ah_d;
      s1_bh_q    <= s1_bh_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_c32_q   <= s2_c32_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

  // Result side comes straight from stage 2; in_ready is the only comb output.
  assign bus.in_ready  = s1_adv_s;
  assign bus.out_valid = s2_valid_q;
  assign bus.S         = s2_sum_q;
  assign bus.C32       = s2_c32_q;
  assign bus.OVF       = s2_ovf_q;
endmodule
